// File: rtl/cp0_random_tlbwr_pkg.sv
// Shared CP0 definitions for the Random/TLB write-index block.
// Holds the CP0 register numbers used around the TLB, the default TLB
// geometry and the encoding of the TLB write sequencer states.
package cp0_random_tlbwr_pkg;

    // CP0 register numbers (rd field of MTC0/MFC0)
    localparam logic [4:0] CP0_REG_INDEX  = 5'd0;
    localparam logic [4:0] CP0_REG_RANDOM = 5'd1;
    localparam logic [4:0] CP0_REG_WIRED  = 5'd6;

    // Default TLB geometry; IDX_W must equal log2(TLB_ENTRIES)
    localparam int TLB_ENTRIES_DEF = 16;
    localparam int IDX_W_DEF       = 4;

    // TLB write sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } tlbw_state_e;

endpackage

// File: rtl/cp0_random_tlbwr_random_counter.sv
// CP0 Random register counter.
// Counts down through the non-wired entries [w, TLB_ENTRIES-1] and wraps to
// the top entry, so a TLBWR never lands on a wired entry.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   hold      - freeze the counter (pipeline stall or TLB write in flight)
//   wired_we  - Wired register written this cycle; restarts at the top
//   wired_w   - low IDX_W bits of the Wired register
//   random    - current Random value
module random_counter
    import cp0_random_tlbwr_pkg::*;
#(
    parameter int TLB_ENTRIES = TLB_ENTRIES_DEF,
    parameter int IDX_W       = IDX_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold,
    input  logic             wired_we,
    input  logic [IDX_W-1:0] wired_w,
    output logic [IDX_W-1:0] random
);

    localparam logic [IDX_W-1:0] RANDOM_TOP = IDX_W'(TLB_ENTRIES - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO   = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_ONE    = {{(IDX_W-1){1'b0}}, 1'b1};

    logic [IDX_W-1:0] random_r;

    // Random register: Wired write beats hold; wrap when at or below Wired.
    // With w == TLB_ENTRIES-1 the wrap term is always true, pinning the top.
    always_ff @(posedge clk) begin
        if (rst) begin
            random_r <= RANDOM_TOP;
        end else if (wired_we) begin
            random_r <= RANDOM_TOP;
        end else if (hold) begin
            random_r <= random_r;
        end else if ((random_r <= wired_w) || (random_r == IDX_ZERO)) begin
            random_r <= RANDOM_TOP;
        end else begin
            random_r <= random_r - IDX_ONE;
        end
    end

    assign random = random_r;

endmodule

// File: rtl/cp0_random_tlbwr.sv
// CP0 Random register and TLB write-index issuer for TLBWR/TLBWI.
// A TLBWI writes the entry named by Index, a TLBWR the entry named by Random.
// The write is held on the TLB port until tlb_ack, then done pulses once.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   stall               - pipeline stall; Random does not advance
//   wired_we, wired_q   - Wired register write strobe and current value
//   index_q             - current Index register value
//   tlbwr_req/tlbwi_req - one-cycle issue pulses from MEM
//   tlb_we, tlb_idx     - TLB write strobe and entry, held until tlb_ack
//   tlb_ack             - TLB has committed the write
//   busy                - write in flight, pipeline must stall
//   done                - one-cycle completion pulse
//   random_q            - MFC0 Random read value (zero-extended)
module cp0_random_tlbwr
    import cp0_random_tlbwr_pkg::*;
#(
    parameter int TLB_ENTRIES = TLB_ENTRIES_DEF,
    parameter int IDX_W       = IDX_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             wired_we,
    input  logic [31:0]      wired_q,
    input  logic [31:0]      index_q,
    input  logic             tlbwr_req,
    input  logic             tlbwi_req,
    output logic             tlb_we,
    output logic [IDX_W-1:0] tlb_idx,
    input  logic             tlb_ack,
    output logic             busy,
    output logic             done,
    output logic [31:0]      random_q
);

    tlbw_state_e      state_r;
    tlbw_state_e      state_next_s;
    logic [IDX_W-1:0] idx_next_s;
    logic [IDX_W-1:0] random_s;
    logic             accept_s;
    logic             hold_s;
    logic             unused_s;

    // Only the low IDX_W bits of Wired/Index select a TLB entry
    assign unused_s = ^{wired_q[31:IDX_W], index_q[31:IDX_W]};

    // A request is only taken in IDLE; the pipeline never issues while busy
    assign accept_s = (state_r == ST_IDLE) && (tlbwi_req || tlbwr_req);

    // Random freezes from the issue cycle until the write sequence ends, so
    // the value read back during the write is the entry being written
    assign hold_s = stall || busy || accept_s;

    random_counter #(
        .TLB_ENTRIES(TLB_ENTRIES),
        .IDX_W      (IDX_W)
    ) u_random_counter (
        .clk     (clk),
        .rst     (rst),
        .hold    (hold_s),
        .wired_we(wired_we),
        .wired_w (wired_q[IDX_W-1:0]),
        .random  (random_s)
    );

    assign random_q = {{(32-IDX_W){1'b0}}, random_s};

    // Sequencer next state and captured write index; TLBWI beats TLBWR
    always_comb begin
        state_next_s = state_r;
        idx_next_s   = tlb_idx;
        case (state_r)
            ST_IDLE: begin
                if (tlbwi_req) begin
                    state_next_s = ST_WRITE;
                    idx_next_s   = index_q[IDX_W-1:0];
                end else if (tlbwr_req) begin
                    state_next_s = ST_WRITE;
                    idx_next_s   = random_s;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (tlb_ack) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_WRITE;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Sequencer state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Registered outputs, decoded from the next state so they align with it
    always_ff @(posedge clk) begin
        if (rst) begin
            tlb_we  <= 1'b0;
            tlb_idx <= {IDX_W{1'b0}};
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            tlb_we  <= (state_next_s == ST_WRITE);
            tlb_idx <= idx_next_s;
            busy    <= (state_next_s != ST_IDLE);
            done    <= (state_next_s == ST_DONE);
        end
    end

endmodule

// File: tb/tb_cp0_random_tlbwr.sv
// Directed self-checking bench for cp0_random_tlbwr with 16 TLB entries.
module tb_cp0_random_tlbwr;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        wired_we;
    logic [31:0] wired_q;
    logic [31:0] index_q;
    logic        tlbwr_req;
    logic        tlbwi_req;
    logic        tlb_we;
    logic [3:0]  tlb_idx;
    logic        tlb_ack;
    logic        busy;
    logic        done;
    logic [31:0] random_q;

    int checks = 0;
    int errors = 0;

    cp0_random_tlbwr #(
        .TLB_ENTRIES(16),
        .IDX_W      (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .stall    (stall),
        .wired_we (wired_we),
        .wired_q  (wired_q),
        .index_q  (index_q),
        .tlbwr_req(tlbwr_req),
        .tlbwi_req(tlbwi_req),
        .tlb_we   (tlb_we),
        .tlb_idx  (tlb_idx),
        .tlb_ack  (tlb_ack),
        .busy     (busy),
        .done     (done),
        .random_q (random_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; inputs change and outputs are sampled 1 time unit
    // after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        int min_seen;
        int writes;
        rst       = 1'b1;
        stall     = 1'b0;
        wired_we  = 1'b0;
        wired_q   = 32'd0;
        index_q   = 32'd0;
        tlbwr_req = 1'b0;
        tlbwi_req = 1'b0;
        tlb_ack   = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_random", random_q, 32'd15);
        check("rst_we", {31'd0, tlb_we}, 32'd0);
        check("rst_idx", {28'd0, tlb_idx}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);

        // 1: w = 0, full countdown 15..0 then wrap to 15
        for (int i = 1; i <= 16; i++) begin
            tick();
            check("count_w0", random_q, (i <= 15) ? 32'(15 - i) : 32'd15);
        end

        // 2: Wired = 10 restricts Random to [10,15]
        wired_q  = 32'd10;
        wired_we = 1'b1;
        tick();
        wired_we = 1'b0;
        check("wired10_top", random_q, 32'd15);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("wired10_seq", random_q, (i < 5) ? 32'(14 - i) : 32'd15);
        end
        min_seen = 15;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (int'(random_q) < min_seen) min_seen = int'(random_q);
        end
        check("wired10_min", 32'(min_seen), 32'd10);

        // Back to Wired = 0 and walk Random down to 12
        wired_q  = 32'd0;
        wired_we = 1'b1;
        tick();
        wired_we = 1'b0;
        check("wired0_top", random_q, 32'd15);
        tick();
        tick();
        tick();
        check("pre_tlbwr", random_q, 32'd12);

        // 3: TLBWR at Random = 12, ack on the third write cycle
        tlbwr_req = 1'b1;
        tick();
        tlbwr_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("wr_we", {31'd0, tlb_we}, 32'd1);
            check("wr_idx", {28'd0, tlb_idx}, 32'd12);
            check("wr_busy", {31'd0, busy}, 32'd1);
            check("wr_random", random_q, 32'd12);
            if (i == 2) tlb_ack = 1'b1;
            tick();
        end
        tlb_ack = 1'b0;
        check("wr_done", {31'd0, done}, 32'd1);
        check("wr_done_we", {31'd0, tlb_we}, 32'd0);
        check("wr_done_busy", {31'd0, busy}, 32'd1);
        check("wr_done_random", random_q, 32'd12);
        tick();
        check("wr_idle_busy", {31'd0, busy}, 32'd0);
        check("wr_idle_done", {31'd0, done}, 32'd0);
        check("wr_idle_random", random_q, 32'd12);
        tick();
        check("wr_resume", random_q, 32'd11);

        // 4: TLBWI and TLBWR together at Random = 9, Index = 5
        tick();
        tick();
        check("pre_both", random_q, 32'd9);
        index_q   = 32'd5;
        tlbwi_req = 1'b1;
        tlbwr_req = 1'b1;
        tick();
        tlbwi_req = 1'b0;
        tlbwr_req = 1'b0;
        check("both_we", {31'd0, tlb_we}, 32'd1);
        check("both_idx", {28'd0, tlb_idx}, 32'd5);
        tlb_ack = 1'b1;
        tick();
        tlb_ack = 1'b0;
        check("both_done", {31'd0, done}, 32'd1);
        writes = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (tlb_we) writes++;
        end
        check("both_no_second", 32'(writes), 32'd0);
        check("both_random", random_q, 32'd6);

        // 5: reset in the middle of a write
        tlbwr_req = 1'b1;
        tick();
        tlbwr_req = 1'b0;
        check("mid_we", {31'd0, tlb_we}, 32'd1);
        check("mid_idx", {28'd0, tlb_idx}, 32'd6);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_we", {31'd0, tlb_we}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        check("mid_rst_random", random_q, 32'd15);
        tlbwr_req = 1'b1;
        tick();
        tlbwr_req = 1'b0;
        check("post_rst_we", {31'd0, tlb_we}, 32'd1);
        check("post_rst_idx", {28'd0, tlb_idx}, 32'd15);
        tlb_ack = 1'b1;
        tick();
        tlb_ack = 1'b0;
        check("post_rst_done", {31'd0, done}, 32'd1);
        tick();
        tick();
        check("post_rst_random", random_q, 32'd14);

        // 6: stall at Random = 7, then Wired write during the stall
        for (int i = 0; i < 7; i++) tick();
        check("pre_stall", random_q, 32'd7);
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_hold", random_q, 32'd7);
        end
        wired_we = 1'b1;
        tick();
        wired_we = 1'b0;
        check("stall_wired", random_q, 32'd15);
        stall = 1'b0;
        tick();
        check("stall_release", random_q, 32'd14);

        // Wired write together with TLBWR: old Random captured, Random restarts
        wired_we  = 1'b1;
        tlbwr_req = 1'b1;
        tick();
        wired_we  = 1'b0;
        tlbwr_req = 1'b0;
        check("wired_wr_idx", {28'd0, tlb_idx}, 32'd14);
        check("wired_wr_random", random_q, 32'd15);
        tlb_ack = 1'b1;
        tick();
        tlb_ack = 1'b0;
        check("wired_wr_done", {31'd0, done}, 32'd1);
        tick();
        check("wired_wr_idle", {31'd0, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
